// File: rtl/alu_lockstep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_lockstep_ctrl                                         |
// | Purpose  : Lockstep ALU controller; compares two ALU copies, retries |
// |            on disagreement and flags untrusted results.              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module alu_lockstep_ctrl #(
  parameter int MAX_RETRY = 2,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  input  logic [1:0]       op_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [1:0]       alu_sel,
  input  logic [7:0]       alu_out1,
  input  logic [7:0]       alu_out2,
  input  logic             alu_co1,
  input  logic             alu_co2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_carry,
  output logic             res_fault,
  output logic [2:0]       res_retries,
  output logic             fault_sticky,
  input  logic             fault_clr,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0]       C_MAX_RETRY = 3'(MAX_RETRY);
  localparam logic [ERR_W-1:0] C_ERR_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic             res_fault_q, res_fault_d;
  logic [2:0]       res_retries_q, res_retries_d;
  logic             fault_sticky_q, fault_sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             w_mismatch;

  assign w_mismatch = (alu_out1 != alu_out2) || (alu_co1 != alu_co2);

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_sel_d      = alu_sel_q;
    retry_d        = retry_q;
    res_data_d     = res_data_q;
    res_carry_d    = res_carry_q;
    res_fault_d    = res_fault_q;
    res_retries_d  = res_retries_q;
    // A clear takes effect before any event counted in the same cycle.
    err_cnt_d      = fault_clr ? '0 : err_cnt_q;
    fault_sticky_d = fault_clr ? 1'b0 : fault_sticky_q;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          alu_a_d   = op_a;
          alu_b_d   = op_b;
          alu_sel_d = op_sel;
          retry_d   = 3'd0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (w_mismatch && (err_cnt_d != C_ERR_MAX)) begin
          err_cnt_d = err_cnt_d + 1'b1;
        end
        if (w_mismatch && (retry_q < C_MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          state_d = EXEC;
        end else begin
          res_data_d    = alu_out1;
          res_carry_d   = alu_co1;
          res_fault_d   = w_mismatch;
          res_retries_d = retry_q;
          if (w_mismatch) begin
            fault_sticky_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      alu_a_q        <= 8'd0;
      alu_b_q        <= 8'd0;
      alu_sel_q      <= 2'd0;
      retry_q        <= 3'd0;
      res_data_q     <= 8'd0;
      res_carry_q    <= 1'b0;
      res_fault_q    <= 1'b0;
      res_retries_q  <= 3'd0;
      fault_sticky_q <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_sel_q      <= alu_sel_d;
      retry_q        <= retry_d;
      res_data_q     <= res_data_d;
      res_carry_q    <= res_carry_d;
      res_fault_q    <= res_fault_d;
      res_retries_q  <= res_retries_d;
      fault_sticky_q <= fault_sticky_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign op_ready     = (state_q == IDLE);
  assign res_valid    = (state_q == RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign res_data     = res_data_q;
  assign res_carry    = res_carry_q;
  assign res_fault    = res_fault_q;
  assign res_retries  = res_retries_q;
  assign fault_sticky = fault_sticky_q;
  assign err_cnt      = err_cnt_q;

endmodule
`default_nettype wire
